// File: rtl/axis_uart_tx_gen.sv
// AXI-Stream to UART serialiser: one accepted beat is sent as up to CHARS characters,
// with runtime baud divisor, optional parity, tkeep-selected characters and tlast framing.
module axis_uart_tx_gen #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int STOP_BITS      = 1,
    parameter int BYTE_ORDER     = 0,
    parameter int DIV_WIDTH      = 16
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [DIV_WIDTH-1:0]                  baud_div,
    input  logic [AXI_DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic [AXI_DATA_WIDTH/DATA_BITS-1:0]   s_axis_tkeep,
    input  logic                                  s_axis_tlast,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic                                  uart_tx,
    output logic                                  tx_busy,
    output logic                                  tx_done,
    output logic                                  frame_done
);

    localparam int CHARS = AXI_DATA_WIDTH / DATA_BITS;
    localparam int IDXW  = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam int BCW   = $clog2(DATA_BITS + 1);

    localparam logic [BCW-1:0]       LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0]       LAST_STOP = BCW'(STOP_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV   = DIV_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    // Next character: highest pending index for MSB-first, lowest for LSB-first.
    function automatic logic [IDXW-1:0] pick_char(input logic [CHARS-1:0] mask);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = 0; i < CHARS; i++) begin
            int k;
            k = (BYTE_ORDER == 0) ? i : (CHARS - 1 - i);
            if (mask[k]) r = IDXW'(k);
        end
        return r;
    endfunction

    function automatic logic [DATA_BITS-1:0] char_at(input logic [AXI_DATA_WIDTH-1:0] word,
                                                     input logic [IDXW-1:0]           idx);
        int base;
        base = int'(idx) * DATA_BITS;
        return word[base +: DATA_BITS];
    endfunction

    function automatic logic parity_of(input logic [DATA_BITS-1:0] c);
        return (^c) ^ (PARITY_MODE == 2);
    endfunction

    state_t                  state_q, state_d;
    logic [DIV_WIDTH-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CHARS-1:0]        pend_q, pend_d;
    logic                    uart_tx_q, uart_tx_d;
    logic                    tready_q, tready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    frame_q, frame_d;

    logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                      tlast_q, tlast_d;
    logic [DIV_WIDTH-1:0]      div_q, div_d;
    logic [DATA_BITS-1:0]      char_q, char_d;
    logic                      par_q, par_d;

    logic [CHARS-1:0]          sel_mask;
    logic [AXI_DATA_WIDTH-1:0] sel_word;
    logic [IDXW-1:0]           sel_idx;
    logic [DATA_BITS-1:0]      sel_char;
    logic [CHARS-1:0]          sel_onehot;
    logic                      bit_tick;
    logic                      load_char;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q;
        pend_d     = pend_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        div_d      = div_q;
        char_d     = char_q;
        par_d      = par_q;
        load_char  = 1'b0;

        // In IDLE the first character comes straight from the bus so START follows transfer.
        sel_mask = (state_q == IDLE) ? s_axis_tkeep : pend_q;
        sel_word = (state_q == IDLE) ? s_axis_tdata : tdata_q;
        sel_idx  = pick_char(sel_mask);
        sel_char = char_at(sel_word, sel_idx);
        for (int i = 0; i < CHARS; i++) begin
            sel_onehot[i] = (IDXW'(i) == sel_idx);
        end

        bit_tick = (baud_cnt_q == div_q - 1'b1);

        case (state_q)
            IDLE: begin
                if (s_axis_tvalid && tready_q) begin
                    tdata_d = s_axis_tdata;
                    tlast_d = s_axis_tlast;
                    div_d   = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
                    if (s_axis_tkeep == '0) begin
                        state_d = DONE;
                    end else begin
                        load_char = 1'b1;
                    end
                end
            end
            START: begin
                baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
                if (bit_tick) begin
                    char_d = char_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
                if (bit_tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_d = '0;
                        if (pend_q != '0) begin
                            load_char = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_char) begin
            state_d   = START;
            char_d    = sel_char;
            par_d     = parity_of(sel_char);
            pend_d    = sel_mask & ~sel_onehot;
            bit_cnt_d = '0;
        end

        // The line follows the current state, giving one cycle from transfer to start bit.
        case (state_q)
            START:   uart_tx_d = 1'b0;
            DATA:    uart_tx_d = char_q[0];
            PARITY:  uart_tx_d = par_q;
            default: uart_tx_d = 1'b1;
        endcase

        tready_d = (state_d == IDLE);
        busy_d   = (state_d == START) || (state_d == DATA) ||
                   (state_d == PARITY) || (state_d == STOP);
        done_d   = (state_d == DONE);
        frame_d  = (state_d == DONE) && tlast_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            pend_q     <= '0;
            uart_tx_q  <= 1'b1;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            pend_q     <= pend_d;
            uart_tx_q  <= uart_tx_d;
            tready_q   <= tready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            frame_q    <= frame_d;
        end
    end

    always_ff @(posedge aclk) begin
        tdata_q <= tdata_d;
        tlast_q <= tlast_d;
        div_q   <= div_d;
        char_q  <= char_d;
        par_q   <= par_d;
    end

    assign s_axis_tready = tready_q;
    assign uart_tx       = uart_tx_q;
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign frame_done    = frame_q;

endmodule

// File: doc/axis_uart_tx_gen.md
Name: axis_uart_tx_gen

Overview:
Parametrised AXI-Stream to UART serialiser. It is the next generation of the fixed-format UART transmitter. It adds the following over the fixed-format block:
- runtime baud divisor
- none/even/odd parity
- tkeep-based partial beats and tlast-delimited frames
- selectable character order
- a busy flag

It sits between an AXI-Stream source (DMA/FIFO) and the board TX pin, one beat serialised as CHARS characters.

Parameters:
AXI_DATA_WIDTH, 32, tdata width; must be a multiple of DATA_BITS.
DATA_BITS, 8, data bits per character, legal 5..9.
PARITY_MODE, 1, 0 = no parity bit, 1 = even, 2 = odd.
STOP_BITS, 1, stop-bit periods, legal 1 or 2.
BYTE_ORDER, 0, 0 = most-significant character first; 1 = least-significant character first.
DIV_WIDTH, 16, width of baud_div.
CHARS (localparam), AXI_DATA_WIDTH/DATA_BITS, characters per beat.

Ports:
aclk  in  1  clock; all logic on rising edge.
areset  in  1  synchronous, active-high reset.
baud_div  in  DIV_WIDTH  aclk cycles per UART bit; latched at beat acceptance.
s_axis_tdata  in  AXI_DATA_WIDTH  beat payload.
s_axis_tkeep  in  CHARS  per-character enable; bit i covers tdata[i*DATA_BITS +: DATA_BITS].
s_axis_tlast  in  1  marks final beat of a frame.
s_axis_tvalid  in  1  source valid.
s_axis_tready  out  1  sink ready.
uart_tx  out  1  serial line, idle high, registered.
tx_busy  out  1  high from acceptance until last stop bit of the beat completes.
tx_done  out  1  one-cycle pulse after every beat completes.
frame_done  out  1  one-cycle pulse coincident with tx_done when the completed beat had tlast=1.

Behaviour:
- Reset, applied at the clock edge when areset=1, forces these values:
  - uart_tx=1, s_axis_tready=0, tx_busy=0, tx_done=0, frame_done=0.
  - FSM=IDLE, all counters 0.
  - A beat in flight is discarded with no partial stop bit. Line is high on the edge after reset.
- Handshake:
  - s_axis_tready is registered. It is 1 only in IDLE, and 0 while areset=1.
  - Transfer occurs on tvalid&&tready. tready drops on the next edge.
  - Exactly one beat is held. tdata, tkeep, tlast and baud_div are latched at transfer.
- Baud divisor: effective divisor = max(baud_div, 2). Every bit period lasts exactly the effective divisor cycles. baud_div changes after transfer have no effect until the next beat.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped if PARITY_MODE=0) -> STOP -> (START for next kept character | DONE) -> IDLE.
- Character selection:
  - Pending mask = latched tkeep. The next character is the highest set index (BYTE_ORDER=0) or the lowest set index (BYTE_ORDER=1).
  - The selected bit is cleared when its START begins. Characters with tkeep=0 are skipped with no line time.
- Timing:
  - uart_tx goes low on the first rising edge after the transfer edge, i.e. 1-cycle latency.
  - Data bits go out LSB first.
  - Parity bit: even = XOR of data bits; odd = inverted XOR.
  - STOP drives 1 for STOP_BITS periods.
  - No idle gap between characters of one beat.
- DONE lasts one cycle:
  - tx_done=1; frame_done=latched tlast; tx_busy=0.
  - Then IDLE with tready=1. Minimum 2 idle-high cycles between beats (DONE + IDLE).
- tkeep all zero: beat is accepted with no line activity. FSM goes IDLE -> DONE -> IDLE; tx_done pulses; frame_done pulses if tlast.
- tx_busy = 1 in START, DATA, PARITY, STOP.
- Character duration = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) × effective divisor cycles.
- tvalid deasserted before tready has no effect. tdata changes while not handshaken are ignored.
- Counters:
  - Baud counter is DIV_WIDTH bits and wraps to 0 at divisor-1.
  - Bit counter is $clog2(DATA_BITS+1) bits.
  - No counter overflows for any legal parameter set.

Test Plan:
1. Reset/idle: hold areset 3 cycles with tvalid=1 -> uart_tx=1, tready=0, no transfer. Release -> tready=1 next edge.
2. Single beat, defaults:
   - Stimulus: baud_div=4, tdata=0xA5_3C_0F_81, tkeep=4'hF, tlast=1.
   - Characters in order A5, 3C, 0F, 81; each is 44 cycles.
   - A5 bits: 1,0,1,0,0,1,0,1, parity 0.
   - Total line time 176 cycles; tx_done and frame_done pulse once.
3. Sparse keep: BYTE_ORDER=1, PARITY_MODE=2, tkeep=4'b0101, tdata=0x00_81_00_7E -> characters 0x7E (odd parity 1) then 0x81 (odd parity 1); 88 cycles at div 4; frame_done=0 with tlast=0.
4. Divisor clamp and latch: baud_div=0 -> 2-cycle bits. Change baud_div 2->10 mid-beat -> remaining bits of that beat stay 2 cycles; the next beat uses 10.
5. Back-to-back beats with tvalid held high: second transfer occurs exactly 2 cycles after the first beat's last stop bit ends. Zero-keep beat -> tx_done pulse, no low on uart_tx.
6. Reset mid-DATA: assert areset during bit 3 of a character -> uart_tx=1 next edge, no tx_done. After release, a new beat transmits correctly from its start bit.
